// File: rtl/led_frame_scheduler.sv
// Double-buffered LED frame scheduler: host words fill a back bank, and the front bank is
// replayed to the matrix controller once per refresh tick.
module led_frame_scheduler #(
  parameter int unsigned FRAME_WORDS  = 256,
  parameter int unsigned FRAME_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] host_data,
  input  logic        host_wren,
  input  logic        host_open,
  output logic        host_full,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_en,
  output logic [15:0] frame_count,
  output logic        overrun
);

  localparam int unsigned PtrW = $clog2(FRAME_WORDS);
  localparam int unsigned TmrW = $clog2(FRAME_PERIOD);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FRAME_WORDS - 1);
  localparam logic [TmrW-1:0] LastTmr = TmrW'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            wr_bank_q, wr_bank_d;
  logic            swap_pending_q, swap_pending_d;
  logic            valid_q, valid_d;
  logic            host_open_q;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            overrun_q, overrun_d;
  logic [31:0]     out_data_q;

  // Both banks share one array; the bank select is the address MSB.
  logic [31:0]     mem_q [2*FRAME_WORDS];

  logic tick;
  logic wr_accept;
  logic close;
  logic swap;
  logic rd_bank;

  assign tick      = (tmr_q == LastTmr);
  assign tmr_d     = tick ? '0 : tmr_q + TmrW'(1);
  assign wr_accept = host_wren && !swap_pending_q;
  assign close     = host_open_q && !host_open;
  assign swap      = swap_pending_q && (state_q == StIdle);
  assign rd_bank   = ~wr_bank_q;

  // Writer and bank-swap bookkeeping.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    wr_bank_d      = wr_bank_q;
    swap_pending_d = swap_pending_q;
    valid_d        = valid_q;
    if (swap) begin
      wr_bank_d      = ~wr_bank_q;
      wr_ptr_d       = '0;
      swap_pending_d = 1'b0;
      valid_d        = 1'b1;
    end else if (wr_accept) begin
      if (wr_ptr_q == LastPtr) begin
        // A completed frame survives a simultaneous close.
        swap_pending_d = 1'b1;
        wr_ptr_d       = '0;
      end else if (close) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
    end else if (close && !swap_pending_q) begin
      wr_ptr_d = '0;
    end
  end

  // Reader FSM; a swap in the tick cycle is already visible to the replay it starts.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    out_en        = 1'b0;
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (tick && (valid_q || swap)) begin
          rd_ptr_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          out_en = 1'b1;
          if (rd_ptr_q == LastPtr) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            state_d  = StFetch;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      tmr_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_bank_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      valid_q        <= 1'b0;
      host_open_q    <= 1'b0;
      frame_count_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_bank_q      <= wr_bank_d;
      swap_pending_q <= swap_pending_d;
      valid_q        <= valid_d;
      host_open_q    <= host_open;
      frame_count_q  <= frame_count_d;
      overrun_q      <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[{wr_bank_q, wr_ptr_q}] <= host_data;
    end
  end

  // Synchronous RAM read; the registered word is held for the whole SEND state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q <= '0;
    end else if (state_q == StFetch) begin
      out_data_q <= mem_q[{rd_bank, rd_ptr_q}];
    end
  end

  assign host_full   = swap_pending_q;
  assign out_data    = out_data_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Double-buffered frame scheduler between the host 32-bit write stream and the LED matrix controller. It accepts host words into a back bank and swaps banks only on a frame boundary. It replays the front bank to the matrix controller once per refresh period, so the panel keeps refreshing while the host is idle. It sits on bus_clk, in the path from `user_w_write_32_*` into `led_matrix_ctrl` `data_in`/`data_in_en`.

## Interface
- FRAME_WORDS, 256: words per frame; power of two, 4..1024.
- FRAME_PERIOD, 100000: clk cycles between refresh ticks; must be ≥ 2*FRAME_WORDS+2.
- clk  in  1  bus clock; all logic is on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- host_data  in  32  host word.
- host_wren  in  1  host write strobe; a word is accepted when host_wren && !host_full.
- host_open  in  1  host stream open; its falling edge discards a partial frame.
- host_full  out  1  back bank full, awaiting swap.
- out_ready  in  1  matrix controller can accept a word; tie to 1 if unconditional.
- out_data  out  32  word to the matrix controller.
- out_en  out  1  out_data valid strobe, one cycle per word.
- frame_count  out  16  completed frame replays; wraps at 0xFFFF→0.
- overrun  out  1  sticky: a refresh tick arrived while a replay was still in progress.

## Operation
- Storage: two banks of FRAME_WORDS x 32, with synchronous read and 1-cycle latency. `wr_bank` selects the back bank and `rd_bank = ~wr_bank`.
- Writer:
  - Each accepted word is written to `back[wr_ptr]`, then `wr_ptr` increments.
  - Accepting the word at `wr_ptr == FRAME_WORDS-1` sets `swap_pending`. `host_full` is 1 from the next cycle.
  - While `swap_pending` is set, host_wren is ignored.
- Close: a host_open 1→0 transition with `swap_pending=0` sets `wr_ptr=0` and discards the partial frame.
  - With `swap_pending=1`, the completed frame is kept.
- Swap: occurs in any cycle where the reader FSM is IDLE and `swap_pending=1`. The swap:
  - toggles `wr_bank`;
  - sets `wr_ptr=0` and `swap_pending=0`;
  - sets `valid=1`.
  - host_full falls the following cycle.
- Tick timer: free-running counter 0..FRAME_PERIOD-1. `tick` is asserted when the counter equals FRAME_PERIOD-1.
- Reader FSM:
  - IDLE: if `tick && valid`, set `rd_ptr=0` and go to FETCH. If a swap happens in the same cycle, that replay reads the newly swapped-in bank.
  - FETCH: present `rd_bank[rd_ptr]` to the RAM, then go to SEND.
  - SEND: hold out_data. Assert out_en for one cycle once out_ready=1 (wait in SEND while out_ready=0). On the out_en cycle:
    - if `rd_ptr == FRAME_WORDS-1`: frame_count++ and go to IDLE;
    - otherwise: rd_ptr++ and go to FETCH.
- Overrun: `tick` while the FSM is not IDLE sets `overrun`. The tick is dropped; the replay continues and the next replay waits for the next tick. Only reset clears `overrun`.
- Before the first swap (`valid=0`), ticks are ignored and out_en stays 0.
- Reset (async, any state):
  - outputs: out_en=0, out_data=0, host_full=0, frame_count=0, overrun=0;
  - internal: FSM=IDLE, timer=0, wr_bank=0, wr_ptr=0, rd_ptr=0, swap_pending=0, valid=0.
  - RAM contents are undefined and are never shown, because `valid=0`.

## Timing
- Write acceptance: a word is accepted in the cycle host_wren=1 and host_full=0.
- host_full rises the cycle after the last word is accepted.
- Swap: in the cycle swap_pending=1 and FSM=IDLE; host_full deasserts on the next edge.
- Worst-case host_full stall: one full replay, 2*FRAME_WORDS cycles plus out_ready stalls.
- Replay cadence: tick in IDLE → FETCH next cycle → first out_en 2 cycles after the tick cycle (with out_ready=1).
- Throughput: one out_en every 2 cycles. A full frame takes 2*FRAME_WORDS cycles plus out_ready stalls.
- out_data changes only on the cycle after a FETCH; it is stable whenever out_en=1.
- frame_count updates on the edge after the last out_en.
- Simultaneous events:
  - Write of the last word while a replay is running: the swap waits until the FSM returns to IDLE.
  - host_open falls in the same cycle the last word is accepted: the frame is kept and swap_pending=1.

## Test plan
Bench parameters for all scenarios: FRAME_WORDS=4, FRAME_PERIOD=16.
- Reset then idle: hold 64 cycles → out_en never 1, frame_count=0, host_full=0.
- Write 0xA0..0xA3 → host_full=1 one cycle after the 4th word, swap, host_full=0 next cycle. At the next tick, out_en pulses carry 0xA0,0xA1,0xA2,0xA3 two cycles apart. frame_count=1, then increments by 1 each period with the same data.
- Write 0xB0..0xB3 while a replay of 0xA* is in progress → host_full=1 until that replay ends, then the swap. The current replay finishes with 0xA3; the next replay sends 0xB0..0xB3. A 5th write during host_full is ignored.
- Write 0xC0,0xC1, drop host_open, then write 0xD0..0xD3 → the next replay after the swap sends 0xD0..0xD3; 0xC* never appears.
- Hold out_ready=0 for 20 cycles mid-replay → out_data holds and out_en stays low. overrun=1 after the missed tick. The replay resumes with the next word when out_ready=1; the next replay starts at the following tick.
- Assert reset_n=0 mid-SEND → out_en=0 immediately and all outputs take their reset values. After release, no output appears until a new full frame is written.
